// File: rtl/mc_control_if.sv
// mc_control_if: control bus between the multi-cycle MIPS controller and its datapath/ALU.
// Ports (no module ports; signals grouped by modport):
//   master (controller): drives pc_write, pc_src, ir_write, iord, mem_read, mem_write,
//                        reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluc,
//                        instr_done, halt; samples op, funct, zero, sign
//   slave  (datapath):   the mirror image
interface mc_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       sign;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] aluc;
    logic       instr_done;
    logic       halt;

    modport master (
        input  op, funct, zero, sign,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluc, instr_done, halt
    );

    modport slave (
        output op, funct, zero, sign,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluc, instr_done, halt
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main controller FSM (fetch/decode/execute/memory/writeback).
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset; forces every output to 0 while high
//   bus       mc_control_if.master: op/funct/zero/sign in, datapath and ALU controls out
//   dbg_state current state (STATE_W bits), 0 during reset
// Build option: define ILLEGAL_TRAP_EN to send illegal op/funct to a sticky HALT state;
// otherwise illegal instructions retire as a NOP from DECODE.
module mc_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    mc_control_if.master       bus,
    output logic [STATE_W-1:0] dbg_state
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_CMPS = 4'd5, ALU_CMPU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_JOINT = 4'd10, ALU_SUBZERO = 4'd11;

    typedef enum logic [STATE_W-1:0] {
        FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
        EXEC_R = 6, EXEC_I = 7, ALUWB = 8, BRANCH = 9, JUMP = 10, HALT = 11
    } state_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = HALT;
    localparam logic   ILL_DONE = 1'b0;
    localparam logic   HALT_EN  = 1'b1;
`else
    localparam state_t ILL_NEXT = FETCH;
    localparam logic   ILL_DONE = 1'b1;
    localparam logic   HALT_EN  = 1'b0;
`endif

    state_t state, nxt;
    logic r_legal, is_jr, is_shift, i_alu, mem_op, is_br, is_jmp, legal, br_cond;
    logic [3:0] r_aluc, i_aluc;

    always_comb begin
        r_legal  = bus.op == 6'h00 && bus.funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                   6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        is_jr    = bus.op == 6'h00 && bus.funct == 6'h08;
        is_shift = bus.op == 6'h00 && bus.funct inside {6'h00, 6'h02, 6'h03};
        i_alu    = bus.op inside {[6'h08:6'h0F]};
        mem_op   = bus.op == 6'h23 || bus.op == 6'h2B;
        is_br    = bus.op inside {[6'h04:6'h07]};
        is_jmp   = bus.op == 6'h02 || bus.op == 6'h03;
        legal    = r_legal || is_jr || i_alu || mem_op || is_br || is_jmp;
        r_aluc   = bus.funct inside {6'h20, 6'h21} ? ALU_ADD :
                   bus.funct inside {6'h22, 6'h23} ? ALU_SUB :
                   bus.funct == 6'h24 ? ALU_AND  : bus.funct == 6'h25 ? ALU_OR   :
                   bus.funct == 6'h26 ? ALU_XOR  : bus.funct == 6'h2A ? ALU_CMPS :
                   bus.funct == 6'h2B ? ALU_CMPU : bus.funct == 6'h00 ? ALU_SLL  :
                   bus.funct == 6'h02 ? ALU_SRL  : bus.funct == 6'h03 ? ALU_SRA  : ALU_ADD;
        i_aluc   = bus.op == 6'h0A ? ALU_CMPS : bus.op == 6'h0B ? ALU_CMPU :
                   bus.op == 6'h0C ? ALU_AND  : bus.op == 6'h0D ? ALU_OR   :
                   bus.op == 6'h0E ? ALU_XOR  : bus.op == 6'h0F ? ALU_JOINT : ALU_ADD;
        // op[1] splits beq/bne (compare) from blez/bgtz (sign test); op[0] inverts the sense
        br_cond  = (bus.op[1] ? (bus.zero | bus.sign) : bus.zero) ^ bus.op[0];
    end

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = mem_op ? MEMADR : is_jr ? JUMP : r_legal ? EXEC_R : i_alu ? EXEC_I :
                           is_br ? BRANCH : is_jmp ? JUMP : ILL_NEXT;
            MEMADR:  nxt = bus.op == 6'h23 ? MEMRD : MEMWR;
            MEMRD:   nxt = MEMWB;
            EXEC_R:  nxt = ALUWB;
            EXEC_I:  nxt = ALUWB;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= nxt;
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 2'd0;
        bus.mem_to_reg = 2'd0;
        bus.alu_src_a  = 2'd0;
        bus.alu_src_b  = 3'd0;
        bus.aluc       = ALU_ADD;
        bus.instr_done = 1'b0;
        bus.halt       = 1'b0;
        dbg_state      = rst ? '0 : state;
        if (!rst) begin
            case (state)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.ir_write  = 1'b1;
                    bus.alu_src_b = 3'd1;
                    bus.pc_write  = 1'b1;
                end
                DECODE: begin
                    bus.alu_src_b  = 3'd3;
                    bus.instr_done = ILL_DONE & ~legal;
                end
                MEMADR: begin
                    bus.alu_src_a = 2'd1;
                    bus.alu_src_b = 3'd2;
                end
                MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 2'd1;
                    bus.instr_done = 1'b1;
                end
                MEMWR: begin
                    bus.mem_write  = 1'b1;
                    bus.iord       = 1'b1;
                    bus.instr_done = 1'b1;
                end
                EXEC_R: begin
                    bus.alu_src_a = is_shift ? 2'd2 : 2'd1;
                    bus.aluc      = r_aluc;
                end
                EXEC_I: begin
                    bus.alu_src_a = 2'd1;
                    bus.alu_src_b = bus.op >= 6'h0C ? 3'd4 : 3'd2;
                    bus.aluc      = i_aluc;
                end
                ALUWB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = bus.op == 6'h00 ? 2'd1 : 2'd0;
                    bus.instr_done = 1'b1;
                end
                BRANCH: begin
                    bus.pc_src     = 2'd1;
                    bus.alu_src_a  = 2'd1;
                    bus.aluc       = bus.op[1] ? ALU_SUBZERO : ALU_SUB;
                    bus.pc_write   = br_cond;
                    bus.instr_done = 1'b1;
                end
                JUMP: begin
                    bus.pc_write   = 1'b1;
                    bus.pc_src     = is_jr ? 2'd3 : 2'd2;
                    bus.reg_write  = bus.op == 6'h03;
                    bus.reg_dst    = bus.op == 6'h03 ? 2'd2 : 2'd0;
                    bus.mem_to_reg = bus.op == 6'h03 ? 2'd2 : 2'd0;
                    bus.instr_done = 1'b1;
                end
                HALT: bus.halt = HALT_EN;
                default: ;
            endcase
        end
    end
endmodule
